// File: rtl/tdc_pkg.sv
// Shared definitions for the timestamp readout path: FIFO word width,
// default frame marker and the reader state encoding.
package tdc_pkg;

  localparam int         FIFO_DW       = 32;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WAIT = 2'd2,
    S_SEND = 2'd3
  } rd_state_t;

endpackage

// File: rtl/memory_reader.sv
// Drains the timestamp FIFO one word at a time and streams each word
// MSB-first as bytes (optionally behind a sync byte) to the UART transmitter.
module memory_reader
  import tdc_pkg::*;
#(
  parameter int         RD_LATENCY = 2,
  parameter int         SYNC_EN    = 1,
  parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE,
  parameter int         CNT_W      = 16
) (
  input  logic               Rclk,
  input  logic               Rst_n,
  input  logic               enable,
  input  logic               fifo_empty,
  input  logic               fifo_rd_err,
  input  logic [FIFO_DW-1:0] fifo_data,
  output logic               ReadEN,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   words_sent,
  output logic               rd_err_flag
);

  localparam int         SYNC_N   = (SYNC_EN != 0) ? 1 : 0;
  localparam int         NB       = 4 + SYNC_N;
  localparam logic [2:0] LAST_IDX = 3'(NB - 1);
  localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY - 1);

  rd_state_t          state_reg, state_next;
  logic [1:0]         lat_cnt_reg, lat_cnt_next;
  logic [2:0]         byte_idx_reg, byte_idx_next;
  logic [31:0]        word_q_reg, word_q_next;
  logic               tx_valid_reg, tx_valid_next;
  logic [CNT_W-1:0]   words_sent_reg, words_sent_next;
  logic               read_en_reg;
  logic               busy_reg;
  logic               rd_err_reg;
  logic               handshake;
  logic [2:0]         data_idx;
  logic [7:0]         tx_data_mux;

  assign handshake = tx_valid_reg & tx_ready;

  always_comb begin
    state_next      = state_reg;
    lat_cnt_next    = lat_cnt_reg;
    byte_idx_next   = byte_idx_reg;
    word_q_next     = word_q_reg;
    tx_valid_next   = tx_valid_reg;
    words_sent_next = words_sent_reg;
    case (state_reg)
      S_IDLE: begin
        if (enable && !fifo_empty) state_next = S_RD;
      end
      S_RD: begin
        lat_cnt_next = LAT_LOAD;
        state_next   = S_WAIT;
      end
      S_WAIT: begin
        // Capture lands RD_LATENCY edges after the edge that sampled ReadEN.
        if (lat_cnt_reg == 2'd0) begin
          word_q_next   = fifo_data;
          byte_idx_next = 3'd0;
          tx_valid_next = 1'b1;
          state_next    = S_SEND;
        end else begin
          lat_cnt_next = lat_cnt_reg - 2'd1;
        end
      end
      S_SEND: begin
        if (handshake) begin
          if (byte_idx_reg == LAST_IDX) begin
            words_sent_next = words_sent_reg + CNT_W'(1);
            tx_valid_next   = 1'b0;
            byte_idx_next   = 3'd0;
            state_next      = S_IDLE;
          end else begin
            byte_idx_next = byte_idx_reg + 3'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Rclk) begin
    if (!Rst_n) begin
      state_reg      <= S_IDLE;
      lat_cnt_reg    <= 2'd0;
      byte_idx_reg   <= 3'd0;
      word_q_reg     <= 32'd0;
      tx_valid_reg   <= 1'b0;
      words_sent_reg <= '0;
      read_en_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      rd_err_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lat_cnt_reg    <= lat_cnt_next;
      byte_idx_reg   <= byte_idx_next;
      word_q_reg     <= word_q_next;
      tx_valid_reg   <= tx_valid_next;
      words_sent_reg <= words_sent_next;
      read_en_reg    <= (state_next == S_RD);
      busy_reg       <= (state_next != S_IDLE);
      rd_err_reg     <= rd_err_reg | fifo_rd_err;
    end
  end

  // With a sync byte in front, data bytes sit one index further along.
  assign data_idx = byte_idx_reg - 3'(SYNC_N);

  always_comb begin
    tx_data_mux = 8'h00;
    if (tx_valid_reg) begin
      if (SYNC_N == 1 && byte_idx_reg == 3'd0) begin
        tx_data_mux = SYNC_BYTE;
      end else begin
        case (data_idx)
          3'd0:    tx_data_mux = word_q_reg[31:24];
          3'd1:    tx_data_mux = word_q_reg[23:16];
          3'd2:    tx_data_mux = word_q_reg[15:8];
          3'd3:    tx_data_mux = word_q_reg[7:0];
          default: tx_data_mux = 8'h00;
        endcase
      end
    end
  end

  assign ReadEN      = read_en_reg;
  assign tx_data     = tx_data_mux;
  assign tx_valid    = tx_valid_reg;
  assign busy        = busy_reg;
  assign words_sent  = words_sent_reg;
  assign rd_err_flag = rd_err_reg;

endmodule
